// File: rtl/pc_sequencer_if.sv
// ============================================================================
//  Module      : pc_sequencer_if
//  Description : Control/datapath bundle between pc_sequencer and the PC/IR path.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface pc_sequencer_if #(
    parameter int ADDR_W = 10
);
    logic              run;
    logic              step;
    logic              clear;
    logic              mem_ready;
    logic              halt_instr;
    logic              branch_take;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] PC_output;

    logic              PC_en;
    logic [ADDR_W-1:0] PC_input;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              ir_load;
    logic              halted;
    logic              fault;

    modport master (
        input  run, step, clear, mem_ready, halt_instr,
               branch_take, branch_target, PC_output,
        output PC_en, PC_input, fetch_req, fetch_addr,
               ir_load, halted, fault
    );

    modport slave (
        output run, step, clear, mem_ready, halt_instr,
               branch_take, branch_target, PC_output,
        input  PC_en, PC_input, fetch_req, fetch_addr,
               ir_load, halted, fault
    );
endinterface

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
//  Module      : pc_sequencer
//  Description : Fetch/decode/execute controller driving the CPU program counter.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module pc_sequencer #(
    parameter int          ADDR_W    = 10,
    parameter int unsigned RESET_VEC = 0,
    parameter int          WAIT_MAX  = 15
) (
    input  wire logic       clock,
    input  wire logic       reset,
    pc_sequencer_if.master  seq
);

    localparam int CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
    localparam logic [ADDR_W-1:0] C_RESET_VEC = ADDR_W'(RESET_VEC);
    localparam logic [CNT_W-1:0]  C_WAIT_LAST = CNT_W'(WAIT_MAX - 1);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_FETCH  = 3'd2,
        S_WAIT   = 3'd3,
        S_DECODE = 3'd4,
        S_EXEC   = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t            state_q,      state_d;
    logic              pc_en_q,      pc_en_d;
    logic [ADDR_W-1:0] pc_input_q,   pc_input_d;
    logic              fetch_req_q,  fetch_req_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic              ir_load_q,    ir_load_d;
    logic              halted_q,     halted_d;
    logic              fault_q,      fault_d;
    logic [CNT_W-1:0]  wait_cnt_q,   wait_cnt_d;
    logic              step_mode_q,  step_mode_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_INIT;
            pc_en_q      <= 1'b0;
            pc_input_q   <= C_RESET_VEC;
            fetch_req_q  <= 1'b0;
            fetch_addr_q <= '0;
            ir_load_q    <= 1'b0;
            halted_q     <= 1'b0;
            fault_q      <= 1'b0;
            wait_cnt_q   <= '0;
            step_mode_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_en_q      <= pc_en_d;
            pc_input_q   <= pc_input_d;
            fetch_req_q  <= fetch_req_d;
            fetch_addr_q <= fetch_addr_d;
            ir_load_q    <= ir_load_d;
            halted_q     <= halted_d;
            fault_q      <= fault_d;
            wait_cnt_q   <= wait_cnt_d;
            step_mode_q  <= step_mode_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_en_d      = 1'b0;
        pc_input_d   = pc_input_q;
        fetch_req_d  = fetch_req_q;
        fetch_addr_d = fetch_addr_q;
        ir_load_d    = 1'b0;
        halted_d     = halted_q;
        fault_d      = fault_q;
        wait_cnt_d   = wait_cnt_q;
        step_mode_d  = step_mode_q;

        case (state_q)
            S_INIT: begin
                pc_en_d    = 1'b1;
                pc_input_d = C_RESET_VEC;
                state_d    = S_IDLE;
            end
            S_IDLE: begin
                if (seq.run) begin
                    step_mode_d = 1'b0;
                    state_d     = S_FETCH;
                end else if (seq.step) begin
                    step_mode_d = 1'b1;
                    state_d     = S_FETCH;
                end
            end
            S_FETCH: begin
                // The PC register loads at the end of this cycle, so forward a pending load.
                fetch_addr_d = pc_en_q ? pc_input_q : seq.PC_output;
                fetch_req_d  = 1'b1;
                wait_cnt_d   = '0;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                if (seq.mem_ready) begin
                    fetch_req_d = 1'b0;
                    ir_load_d   = 1'b1;
                    state_d     = S_DECODE;
                end else if (wait_cnt_q == C_WAIT_LAST) begin
                    fetch_req_d = 1'b0;
                    fault_d     = 1'b1;
                    halted_d    = 1'b1;
                    state_d     = S_HALT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (seq.halt_instr) begin
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                pc_en_d    = 1'b1;
                pc_input_d = seq.branch_take ? seq.branch_target
                                             : seq.PC_output + 1'b1;
                state_d    = (step_mode_q || !seq.run) ? S_IDLE : S_FETCH;
            end
            S_HALT: begin
                if (seq.clear) begin
                    halted_d = 1'b0;
                    fault_d  = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    assign seq.PC_en      = pc_en_q;
    assign seq.PC_input   = pc_input_q;
    assign seq.fetch_req  = fetch_req_q;
    assign seq.fetch_addr = fetch_addr_q;
    assign seq.ir_load    = ir_load_q;
    assign seq.halted     = halted_q;
    assign seq.fault      = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Self-checking bench for pc_sequencer with an instruction-level model.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    localparam int C_ADDR_W   = 10;
    localparam int C_WAIT_MAX = 15;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pc_sequencer_if #(.ADDR_W(C_ADDR_W)) bus ();

    pc_sequencer #(
        .ADDR_W   (C_ADDR_W),
        .RESET_VEC(0),
        .WAIT_MAX (C_WAIT_MAX)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .seq  (bus)
    );

    // Datapath PC register owned by the bench.
    logic [C_ADDR_W-1:0] pc_reg = '0;
    logic                pc_force_en = 1'b0;
    logic [C_ADDR_W-1:0] pc_force_val = '0;
    always @(posedge clk) begin
        if (pc_force_en)    pc_reg <= pc_force_val;
        else if (bus.PC_en) pc_reg <= bus.PC_input;
    end
    assign bus.PC_output = pc_reg;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0, wcnt = 0, cur_delay = 0;
    int pcen_cnt = 0, irl_cnt = 0;
    logic prev_pcen = 1'b0;
    logic [C_ADDR_W-1:0] model_pc = '0;

    int                  dly [64];
    bit                  br  [64];
    logic [C_ADDR_W-1:0] tgt [64];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: sample outputs after the edge, play program memory, track pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.fetch_req) begin
            bus.mem_ready = (wcnt >= cur_delay);
            wcnt++;
        end else begin
            bus.mem_ready = 1'b0;
            wcnt = 0;
        end
        if (bus.PC_en) begin
            pcen_cnt++;
            check_val("pc_en_consecutive", 32'(prev_pcen), 32'd0);
        end
        prev_pcen = bus.PC_en;
        if (bus.ir_load) irl_cnt++;
    endtask

    task automatic force_pc(input logic [C_ADDR_W-1:0] v);
        pc_force_val = v;
        pc_force_en  = 1'b1;
        tick();
        pc_force_en  = 1'b0;
        model_pc     = v;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) begin
            dly[i] = 0;
            br[i]  = 1'b0;
            tgt[i] = '0;
        end
    endtask

    // Free-run n instructions from IDLE; run drops during the last one.
    task automatic run_program(input int n, input bit fill_rnd);
        logic [C_ADDR_W-1:0] exp_addr, nxt;
        int k, last_en, budget, en_before;
        if (fill_rnd) begin
            for (int i = 0; i < n; i++) begin
                dly[i] = $urandom_range(0, 3);
                br[i]  = ($urandom_range(0, 3) == 0);
                tgt[i] = C_ADDR_W'($urandom);
            end
        end
        exp_addr = model_pc;
        k = 0; last_en = -1; budget = n * 12 + 20;
        cur_delay = dly[0];
        bus.branch_take   = br[0];
        bus.branch_target = tgt[0];
        bus.halt_instr    = 1'b0;
        bus.run           = 1'b1;
        while (k < n && budget > 0) begin
            tick();
            budget--;
            if (bus.ir_load) begin
                check_val("fetch_addr", 32'(bus.fetch_addr), 32'(exp_addr));
                if (k == n - 1) bus.run = 1'b0;
            end
            if (bus.PC_en) begin
                nxt = br[k] ? tgt[k] : exp_addr + 1'b1;
                check_val("pc_input", 32'(bus.PC_input), 32'(nxt));
                if (last_en >= 0) check_val("instr_cycles", 32'(cyc - last_en), 32'(4 + dly[k]));
                last_en  = cyc;
                exp_addr = nxt;
                k++;
                if (k < n) begin
                    cur_delay         = dly[k];
                    bus.branch_take   = br[k];
                    bus.branch_target = tgt[k];
                end
            end
        end
        check_val("run_instr_count", 32'(k), 32'(n));
        model_pc = exp_addr;
        en_before = pcen_cnt;
        bus.branch_take = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        check_val("run_stopped_no_exec", 32'(pcen_cnt - en_before), 32'd0);
        check_val("run_stopped_fetch_req", 32'(bus.fetch_req), 32'd0);
        check_val("run_final_pc", 32'(pc_reg), 32'(model_pc));
    endtask

    task automatic step_test(input logic [C_ADDR_W-1:0] start);
        int en_before, ir_before;
        logic [C_ADDR_W-1:0] nxt;
        force_pc(start);
        nxt = start + 1'b1;
        bus.run = 1'b0;
        bus.branch_take = 1'b0;
        bus.halt_instr = 1'b0;
        cur_delay = 2;
        en_before = pcen_cnt;
        ir_before = irl_cnt;
        bus.step = 1'b1;
        tick();
        for (int c = 0; c < 14; c++) begin
            bus.step = (c == 2);
            tick();
            if (bus.ir_load) check_val("step_fetch_addr", 32'(bus.fetch_addr), 32'(start));
            if (bus.PC_en)   check_val("step_pc_input", 32'(bus.PC_input), 32'(nxt));
        end
        bus.step = 1'b0;
        check_val("step_exec_count", 32'(pcen_cnt - en_before), 32'd1);
        check_val("step_fetch_count", 32'(irl_cnt - ir_before), 32'd1);
        check_val("step_idle_fetch_req", 32'(bus.fetch_req), 32'd0);
        model_pc = nxt;
        check_val("step_final_pc", 32'(pc_reg), 32'(model_pc));
    endtask

    initial begin : g_watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int wcycles, en_before, guard;
        bus.run = 1'b0; bus.step = 1'b0; bus.clear = 1'b0;
        bus.mem_ready = 1'b0; bus.halt_instr = 1'b0;
        bus.branch_take = 1'b0; bus.branch_target = '0;
        clear_prog();

        // Reset and INIT load
        rst_n = 1'b0;
        tick(); tick();
        check_val("rst_pc_en",      32'(bus.PC_en),      32'd0);
        check_val("rst_pc_input",   32'(bus.PC_input),   32'd0);
        check_val("rst_fetch_req",  32'(bus.fetch_req),  32'd0);
        check_val("rst_fetch_addr", 32'(bus.fetch_addr), 32'd0);
        check_val("rst_ir_load",    32'(bus.ir_load),    32'd0);
        check_val("rst_halted",     32'(bus.halted),     32'd0);
        check_val("rst_fault",      32'(bus.fault),      32'd0);
        rst_n = 1'b1;
        tick();
        check_val("init_pc_en",    32'(bus.PC_en),    32'd1);
        check_val("init_pc_input", 32'(bus.PC_input), 32'd0);
        tick();
        check_val("idle_pc_en",     32'(bus.PC_en),     32'd0);
        check_val("idle_fetch_req", 32'(bus.fetch_req), 32'd0);
        model_pc = '0;
        check_val("init_pc_loaded", 32'(pc_reg), 32'd0);

        // Straight-line run from 0
        clear_prog();
        run_program(4, 1'b0);

        // Single step with an ignored second step
        step_test(10'd5);

        // Branch then wrap at top of address space
        force_pc(10'h100);
        clear_prog();
        br[0] = 1'b1; tgt[0] = 10'h3F0;
        run_program(2, 1'b0);
        force_pc(10'h3FF);
        clear_prog();
        run_program(2, 1'b0);

        // Fetch timeout
        bus.run = 1'b1;
        cur_delay = 1000;
        wcycles = 0;
        for (int c = 0; c < 40 && !bus.halted; c++) begin
            tick();
            if (bus.fetch_req) wcycles++;
        end
        check_val("timeout_wait_cycles", 32'(wcycles), 32'(C_WAIT_MAX));
        check_val("timeout_halted",    32'(bus.halted),    32'd1);
        check_val("timeout_fault",     32'(bus.fault),     32'd1);
        check_val("timeout_fetch_req", 32'(bus.fetch_req), 32'd0);
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        tick(); tick();
        check_val("halt_ignores_run",  32'(bus.fetch_req), 32'd0);
        check_val("halt_held",         32'(bus.halted),    32'd1);
        bus.run = 1'b0;
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check_val("clear_halted", 32'(bus.halted), 32'd0);
        check_val("clear_fault",  32'(bus.fault),  32'd0);
        tick();
        check_val("clear_idle_fetch_req", 32'(bus.fetch_req), 32'd0);

        // HALT instruction at PC=7
        force_pc(10'd7);
        cur_delay = 0;
        bus.halt_instr = 1'b1;
        bus.run = 1'b1;
        en_before = pcen_cnt;
        for (int c = 0; c < 20 && !bus.halted; c++) tick();
        check_val("hi_halted",  32'(bus.halted), 32'd1);
        check_val("hi_fault",   32'(bus.fault),  32'd0);
        check_val("hi_no_exec", 32'(pcen_cnt - en_before), 32'd0);
        check_val("hi_pc_kept", 32'(pc_reg), 32'd7);
        bus.run = 1'b0;
        bus.halt_instr = 1'b0;
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check_val("hi_clear_halted", 32'(bus.halted), 32'd0);

        // Reset during WAIT
        bus.run = 1'b1;
        cur_delay = 1000;
        guard = 0;
        while (!bus.fetch_req && guard < 10) begin
            tick();
            guard++;
        end
        check_val("wait_reached", 32'(bus.fetch_req), 32'd1);
        tick();
        rst_n = 1'b0;
        tick();
        check_val("midwait_rst_fetch_req", 32'(bus.fetch_req), 32'd0);
        check_val("midwait_rst_pc_en",     32'(bus.PC_en),     32'd0);
        rst_n = 1'b1;
        bus.run = 1'b0;
        tick();
        check_val("midwait_init_pc_en",    32'(bus.PC_en),    32'd1);
        check_val("midwait_init_pc_input", 32'(bus.PC_input), 32'd0);
        tick();
        model_pc = '0;
        check_val("midwait_pc_reloaded", 32'(pc_reg), 32'd0);

        // Randomised free-run programs
        for (int r = 0; r < 6; r++) begin
            if ($urandom_range(0, 1) == 1) force_pc(C_ADDR_W'($urandom));
            run_program($urandom_range(5, 20), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
